// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and types, used by both the program encoder
// and the instruction decoder so the two sides agree on every field.
package mips_pkg;

    // Primary opcodes (instruction bits 31:26)
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function code (instruction bits 5:0)
    localparam logic [5:0] FN_ADDU  = 6'b100001;

    // Symbolic instruction kind carried on the request stream; 5..7 are invalid
    typedef enum logic [2:0] {
        K_ADDU  = 3'd0,
        K_ADDIU = 3'd1,
        K_SW    = 3'd2,
        K_LW    = 3'd3,
        K_JAL   = 3'd4
    } kind_e;

    // Encoder control states
    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Purely combinational packer: turns a symbolic instruction into its 32-bit
// machine word and flags whether the kind is one we know how to encode.
module instr_pack
    import mips_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        kind_ok
);

    // Select the field layout for the requested kind
    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        word    = 32'h0000_0000;
        kind_ok = 1'b0;
        case (kind)
            K_ADDU: begin
                word    = {OP_RTYPE, rs, rt, rd, 5'b00000, FN_ADDU};
                kind_ok = 1'b1;
            end
            K_ADDIU: begin
                word    = {OP_ADDIU, rs, rt, imm};
                kind_ok = 1'b1;
            end
            K_SW: begin
                word    = {OP_SW, rs, rt, imm};
                kind_ok = 1'b1;
            end
            K_LW: begin
                word    = {OP_LW, rs, rt, imm};
                kind_ok = 1'b1;
            end
            K_JAL: begin
                word    = {OP_JAL, target};
                kind_ok = 1'b1;
            end
            default: begin
                word    = 32'h0000_0000;
                kind_ok = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/prog_encoder.sv
// Program encoder: accepts one symbolic instruction per cycle, packs it and
// writes the word to the next instruction-memory address. Stops in DONE at the
// end of the program or when memory is full; restart returns it to RUN.
module prog_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full,
    output logic              err_kind
);

    // count value when memory is full, and the value just before it
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST_CNT  = DEPTH_CNT - {{ADDR_W{1'b0}}, 1'b1};

    enc_state_e        state;
    enc_state_e        next_state;
    logic [31:0]       word;
    logic              kind_ok;
    logic              accept;
    logic [ADDR_W-1:0] ptr;

    instr_pack u_pack (
        .kind    (in_kind),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .word    (word),
        .kind_ok (kind_ok)
    );

    // The write pointer is the low part of count: the block stops before it
    // could wrap, so a separate register would always hold the same value.
    assign ptr    = count[ADDR_W-1:0];
    // restart takes priority over a request presented in the same cycle
    assign accept = in_valid && in_ready && !restart;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: finish on the last instruction or on the write that fills memory
    always_comb begin
        next_state = state;
        if (restart) begin
            next_state = S_RUN;
        end else if (state == S_RUN && accept &&
                     (in_last || (kind_ok && count == LAST_CNT))) begin
            next_state = S_DONE;
        end
    end

    // State-decoded outputs; no path from in_valid to in_ready
    always_comb begin
        in_ready = (state == S_RUN);
        done     = (state == S_DONE);
    end

    assign full = (count == DEPTH_CNT);

    // Write port, counter and sticky error; mem_we is a one-cycle strobe
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0000_0000;
            count     <= '0;
            err_kind  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                if (kind_ok) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= ptr;
                    mem_wdata <= word;
                    count     <= count + {{ADDR_W{1'b0}}, 1'b1};
                end else begin
                    err_kind <= 1'b1;
                end
            end
        end
    end

endmodule
